// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: command codes, the
// legal-code limit and the scheduler state encoding.
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE       = 4'd0;
    localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
    localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
    localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
    localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX         = 4'd5;
    localparam logic [3:0] CMD_MIN         = 4'd6;
    localparam logic [3:0] CMD_AVG         = 4'd7;
    localparam logic [3:0] CMD_ROT_LEFT    = 4'd8;
    localparam logic [3:0] CMD_ROT_RIGHT   = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;

    // Codes at or above this value are handshaken but never queued.
    localparam logic [3:0] CMD_LIMIT       = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_HOLD  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } sched_state_e;

    function automatic logic is_legal(input logic [3:0] code);
        return code < CMD_LIMIT;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without a separate flag.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Queues host commands and issues them one at a time to the LCD controller,
// waiting for the controller to go idle between issues; a WRITE ends the run.
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             host_cmd,
    input  logic                   host_valid,
    output logic                   host_ready,
    output logic [3:0]             lcd_cmd,
    output logic                   lcd_cmd_valid,
    input  logic                   lcd_busy,
    input  logic                   lcd_done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             rej_cnt,
    output logic                   sched_done,
    output sched_state_e           state
);

    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_head;
    logic       accept;
    logic       legal;
    logic       last_write;

    // Host side: a transfer happens on a cycle where host_valid and host_ready
    // are both high; host_ready never depends on host_valid, and a held
    // host_valid with host_ready low transfers nothing and is not counted.
    assign host_ready = !reset && !fifo_full && (state != S_DRAIN) && (state != S_FIN);
    assign accept     = host_valid && host_ready;
    assign legal      = is_legal(host_cmd);

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept && legal),
        .wr_data (host_cmd),
        .pop     (state == S_ISSUE),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rej_cnt <= 8'd0;
        end else if (accept && !legal && (rej_cnt != 8'hff)) begin
            rej_cnt <= rej_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            lcd_cmd_valid <= 1'b0;
            lcd_cmd       <= 4'd0;
            last_write    <= 1'b0;
            sched_done    <= 1'b0;
        end else begin
            lcd_cmd_valid <= 1'b0;
            lcd_cmd       <= 4'd0;
            case (state)
                S_IDLE: begin
                    // The head is captured here and popped during ISSUE.
                    if (!fifo_empty && !lcd_busy) begin
                        state         <= S_ISSUE;
                        lcd_cmd_valid <= 1'b1;
                        lcd_cmd       <= fifo_head;
                        last_write    <= (fifo_head == CMD_WRITE);
                    end
                end
                S_ISSUE: state <= S_HOLD;
                S_HOLD:  state <= S_WAIT;
                S_WAIT: begin
                    if (!lcd_busy) state <= last_write ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (lcd_done) begin
                        state      <= S_FIN;
                        sched_done <= 1'b1;
                    end
                end
                S_FIN:   state <= S_FIN;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
